time_counter_adj: RTL
=====================

Name: time_counter_adj

Overview:
- Parametrised successor to the seconds-resolution time counter of the clock datapath.
- Free-running seconds counter with an internal prescaler, mode control (run / set / hold / run+adjust) and button adjust by second, minute, hour or day.
- All state lives in one clock domain. Increment and decrement are synchronised and edge-detected; they are never used as clocks.
- Output `t` feeds the existing display/decode path unchanged.

Parameters:
- WIDTH, 28, width of the count `t`.
- TICK_DIV, 1, clk cycles per one-second tick; legal range 1..2^24.
- MAX_T, 2**28-1, largest legal count; the tick wraps MAX_T -> 0.
- SAT_ADJ, 1, 1 = adjust saturates at 0 and MAX_T; 0 = adjust wraps modulo MAX_T+1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (reset=0 asserts); release is synchronous to clk.
- enable  in  1  counting enable; gates the prescaler.
- clear  in  1  synchronous clear of `t` and the prescaler.
- increment  in  1  asynchronous level from the debounced button; rising edge = one adjust up.
- decrement  in  1  asynchronous level from the debounced button; rising edge = one adjust down.
- mode  in  2  00 RUN, 01 SET, 10 HOLD, 11 RUN_ADJ.
- selected  in  2  adjust step: 00 = 1, 01 = 60, 10 = 3600, 11 = 86400.
- t  out  WIDTH  current time in seconds.
- tick  out  1  one-cycle pulse in the cycle a second is counted.
- wrapped  out  1  one-cycle pulse when the tick wraps MAX_T -> 0.
- adj_ack  out  1  one-cycle pulse when an adjust is applied to `t`.

Behaviour:
- Reset (reset=0): `t`=0, prescaler=0, synchroniser and edge registers=0, tick=wrapped=adj_ack=0. This holds for reset asserted mid-operation at any cycle.
- Counting: `cnt_en` = enable && (mode==RUN || mode==RUN_ADJ).
  - When `cnt_en` is high, the prescaler increments each cycle.
  - At TICK_DIV-1 the prescaler returns to 0 and `tick_int`=1.
  - When `cnt_en` is low, the prescaler is held at 0.
  - TICK_DIV=1 gives a tick every enabled cycle.
- Adjust path:
  - increment and decrement each pass through a 2-FF synchroniser, then a rising-edge detector.
  - `t` changes on the 3rd clk edge after the input rises; adj_ack pulses in that same cycle.
  - Adjust is accepted only in SET and RUN_ADJ. In RUN and HOLD the edges are discarded, not queued.
  - If increment and decrement edges are detected in the same cycle, both are ignored and adj_ack stays 0.
- `t` update priority:
  1. reset
  2. clear (t=0, prescaler=0, tick/wrapped suppressed)
  3. combined update: `t_next = t + tick_int + (±step if adjust)`, computed in one adder of WIDTH+2 bits.
- Tick wrap: if `t + tick_int > MAX_T`, the tick contribution wraps to 0 and wrapped=1.
- Adjust bounds:
  - SAT_ADJ=1: an increment beyond MAX_T yields MAX_T; a decrement below 0 yields 0. adj_ack still pulses when clamped.
  - SAT_ADJ=0: the result is taken modulo MAX_T+1.
- Tick and adjust in the same cycle: both are applied. Wrap is evaluated on the tick first, then the adjust is bounded.
- HOLD freezes `t` completely, except for clear and reset.
- Outputs are registered; tick, wrapped and adj_ack are never high for two consecutive cycles from a single event.
- Steps wider than WIDTH are truncated at elaboration; synthesis must fail if MAX_T >= 2**WIDTH.

Decomposition:
- Package `time_pkg`:
  - mode encodings MODE_RUN, MODE_SET, MODE_HOLD, MODE_RUN_ADJ;
  - select encodings;
  - step constants STEP_SEC=1, STEP_MIN=60, STEP_HOUR=3600, STEP_DAY=86400.
- Sub-module `sync_edge_detect`: 2-FF synchroniser plus rising-edge pulse, instantiated twice (increment, decrement).
- Prescaler, step mux and bounded adder stay in the top module.

Test Plan:
- Reset and tick: reset=0 for 3 cycles with TICK_DIV=4, mode=RUN, enable=1 -> t=0 during reset; after release, t=1 after 4 cycles, t=5 after 20 cycles, tick every 4th cycle.
- Adjust: mode=SET, selected=01, t=100, one increment pulse -> t=160 exactly 3 clk edges after the rise, adj_ack one cycle. A decrement with selected=11 from t=160 -> t=0 (saturated) with adj_ack=1.
- Wrap: MAX_T=99, t=99, tick -> t=0, wrapped=1. With SAT_ADJ=0 and t=10, decrement with selected=01 -> t=50.
- Simultaneous events:
  - mode=RUN_ADJ, tick and increment (selected=00) in the same cycle, t=7 -> t=9.
  - increment and decrement edges together -> t unchanged, adj_ack=0.
- Mode gating: mode=HOLD, 10 cycles of ticks plus an increment pulse -> t unchanged, no adj_ack. mode=RUN with an increment pulse -> edge ignored, not applied later on switching to SET.
- Reset mid-adjust: increment rises, reset asserted 1 cycle later -> t=0, no adj_ack after release.

Source files
------------

// File: rtl/time_pkg.sv
// Shared encodings and adjust-step constants for the seconds time counter.
package time_pkg;

  typedef enum logic [1:0] {
    MODE_RUN     = 2'b00,
    MODE_SET     = 2'b01,
    MODE_HOLD    = 2'b10,
    MODE_RUN_ADJ = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    SEL_SEC  = 2'b00,
    SEL_MIN  = 2'b01,
    SEL_HOUR = 2'b10,
    SEL_DAY  = 2'b11
  } sel_e;

  localparam longint unsigned STEP_SEC  = 64'd1;
  localparam longint unsigned STEP_MIN  = 64'd60;
  localparam longint unsigned STEP_HOUR = 64'd3600;
  localparam longint unsigned STEP_DAY  = 64'd86400;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser for an asynchronous button level, followed by a
// single-cycle rising-edge pulse.
module sync_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = async_in;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/time_counter_adj.sv
// Seconds counter with prescaler, run/set/hold/run+adjust modes and
// button adjust by second, minute, hour or day.
module time_counter_adj
  import time_pkg::*;
#(
  parameter int unsigned     WIDTH    = 28,
  parameter int unsigned     TICK_DIV = 1,
  parameter longint unsigned MAX_T    = (64'd1 << 28) - 64'd1,
  parameter bit              SAT_ADJ  = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic             increment,
  input  logic             decrement,
  input  logic [1:0]       mode,
  input  logic [1:0]       selected,
  output logic [WIDTH-1:0] t,
  output logic             tick,
  output logic             wrapped,
  output logic             adj_ack
);

  localparam int unsigned     PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);
  localparam int unsigned     AW         = WIDTH + 2;
  localparam longint unsigned MODULUS    = MAX_T + 64'd1;
  localparam logic [AW-1:0]   MAX_X      = AW'(MAX_T);
  localparam logic [AW-1:0]   MOD_X      = AW'(MODULUS);

  // Wrapping mode pre-reduces each step so one correction after the add suffices.
  localparam logic [WIDTH-1:0] STEP_W_SEC  = WIDTH'(SAT_ADJ ? STEP_SEC  : STEP_SEC  % MODULUS);
  localparam logic [WIDTH-1:0] STEP_W_MIN  = WIDTH'(SAT_ADJ ? STEP_MIN  : STEP_MIN  % MODULUS);
  localparam logic [WIDTH-1:0] STEP_W_HOUR = WIDTH'(SAT_ADJ ? STEP_HOUR : STEP_HOUR % MODULUS);
  localparam logic [WIDTH-1:0] STEP_W_DAY  = WIDTH'(SAT_ADJ ? STEP_DAY  : STEP_DAY  % MODULUS);

  if (MAX_T >= (64'd1 << WIDTH)) begin : g_bad_max_t
    $error("time_counter_adj: MAX_T does not fit in WIDTH bits");
  end
  if (TICK_DIV < 1 || TICK_DIV > (32'd1 << 24)) begin : g_bad_tick_div
    $error("time_counter_adj: TICK_DIV outside 1..2^24");
  end

  logic [WIDTH-1:0] t_q, t_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             tick_q, tick_d;
  logic             wrapped_q, wrapped_d;
  logic             adj_ack_q, adj_ack_d;

  logic             inc_pulse, dec_pulse;
  mode_e            mode_m;
  logic             cnt_en, adj_ok, adj_up, adj_dn;
  logic             tick_int, wrap_int, cin;
  logic [WIDTH-1:0] step_w;
  logic [AW-1:0]    op_a, op_b, sum;

  sync_edge_detect u_inc_edge (
    .clk      (clk),
    .rst_n    (reset),
    .async_in (increment),
    .rise     (inc_pulse)
  );

  sync_edge_detect u_dec_edge (
    .clk      (clk),
    .rst_n    (reset),
    .async_in (decrement),
    .rise     (dec_pulse)
  );

  assign mode_m = mode_e'(mode);

  always_comb begin
    cnt_en   = enable && (mode_m == MODE_RUN || mode_m == MODE_RUN_ADJ);
    adj_ok   = (mode_m == MODE_SET || mode_m == MODE_RUN_ADJ);
    adj_up   = adj_ok && inc_pulse && !dec_pulse;
    adj_dn   = adj_ok && dec_pulse && !inc_pulse;
    tick_int = cnt_en && (presc_q == PRESC_LAST);
    presc_d  = (!cnt_en || tick_int) ? '0 : presc_q + PW'(1);

    step_w = STEP_W_SEC;
    case (sel_e'(selected))
      SEL_SEC:  step_w = STEP_W_SEC;
      SEL_MIN:  step_w = STEP_W_MIN;
      SEL_HOUR: step_w = STEP_W_HOUR;
      SEL_DAY:  step_w = STEP_W_DAY;
      default:  step_w = STEP_W_SEC;
    endcase

    // The tick can only overflow from MAX_T itself, so the wrap is resolved
    // on the operands and tick, wrap and adjust share a single adder.
    wrap_int = tick_int && ({2'b00, t_q} == MAX_X);
    op_a     = wrap_int ? '0 : {2'b00, t_q};
    op_b     = '0;
    if (adj_up) op_b = {2'b00, step_w};
    if (adj_dn) op_b = -{2'b00, step_w};
    cin      = tick_int && !wrap_int;
    sum      = op_a + op_b + AW'(cin);

    t_d = sum[WIDTH-1:0];
    if (sum[AW-1]) begin
      if (SAT_ADJ) t_d = '0;
      else         t_d = WIDTH'(sum + MOD_X);
    end else if (sum > MAX_X) begin
      if (SAT_ADJ) t_d = WIDTH'(MAX_X);
      else         t_d = WIDTH'(sum - MOD_X);
    end

    tick_d    = tick_int;
    wrapped_d = wrap_int;
    adj_ack_d = adj_up || adj_dn;

    if (clear) begin
      t_d       = '0;
      presc_d   = '0;
      tick_d    = 1'b0;
      wrapped_d = 1'b0;
      adj_ack_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      t_q       <= '0;
      presc_q   <= '0;
      tick_q    <= 1'b0;
      wrapped_q <= 1'b0;
      adj_ack_q <= 1'b0;
    end else begin
      t_q       <= t_d;
      presc_q   <= presc_d;
      tick_q    <= tick_d;
      wrapped_q <= wrapped_d;
      adj_ack_q <= adj_ack_d;
    end
  end

  assign t       = t_q;
  assign tick    = tick_q;
  assign wrapped = wrapped_q;
  assign adj_ack = adj_ack_q;

endmodule
